// File: rtl/noc_packet_arbiter.sv
// Round-robin, packet-granular (wormhole) arbiter merging CHANNELS flit streams onto one link.
// The grant is held from a packet's first flit until its last flit is accepted downstream.
module noc_packet_arbiter #(
  parameter int unsigned FLIT_WIDTH = 32,
  parameter int unsigned CHANNELS   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] in_flit,
  input  logic [CHANNELS-1:0]            in_last,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]          out_flit,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS-1:0]            grant,
  output logic                           busy
);

  localparam int unsigned PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned SW = PW + 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic [PW-1:0]       gidx_q, gidx_d;
  logic [PW-1:0]       ptr_q, ptr_d;

  logic [2*CHANNELS-1:0] req_dbl;
  logic [CHANNELS-1:0]   req_rot;
  logic                  pick_found;
  logic [PW-1:0]         pick_off;
  logic [SW-1:0]         pick_sum;
  logic [PW-1:0]         pick_idx;
  logic [PW-1:0]         ptr_next;

  // Rotate requests so the pointer channel sits at bit 0; the first set bit is the winner's offset.
  always_comb begin
    req_dbl    = {in_valid, in_valid} >> ptr_q;
    req_rot    = req_dbl[CHANNELS-1:0];
    pick_found = 1'b0;
    pick_off   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (!pick_found && req_rot[i]) begin
        pick_found = 1'b1;
        pick_off   = PW'(i);
      end
    end
    pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
    if (pick_sum > SW'(CHANNELS - 1)) begin
      pick_sum = pick_sum - SW'(CHANNELS);
    end
    pick_idx = pick_sum[PW-1:0];
  end

  // Explicit compare keeps the wrap correct for non-power-of-two channel counts.
  always_comb begin
    if (gidx_q == PW'(CHANNELS - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = gidx_q + 1'b1;
    end
  end

  always_comb begin
    out_flit  = '0;
    out_last  = 1'b0;
    out_valid = 1'b0;
    in_ready  = '0;
    if (state_q == LOCKED) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (grant_q[i]) begin
          out_flit    = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
          out_last    = in_last[i];
          out_valid   = in_valid[i];
          in_ready[i] = out_ready;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = CHANNELS'(1) << pick_idx;
          gidx_d  = pick_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (out_valid && out_ready && out_last) begin
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == LOCKED);

endmodule
